display_channel_sel: RTL



---
 rtl/display_channel_sel.sv | 56 +++++
 1 files changed

// File: rtl/display_channel_sel.sv
// display_channel_sel: registered N-to-1 debug-word selector with manual, auto-scan and freeze modes.
module display_channel_sel #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int DWELL    = 50000000
) (
  input  logic                      CLK,
  input  logic                      Reset,
  input  logic [CHANNELS*WIDTH-1:0] DataIn,
  input  logic [SEL_W-1:0]          SelectCode,
  input  logic                      AutoScan,
  input  logic                      Freeze,
  input  logic                      NextBtn,
  output logic [WIDTH-1:0]          DataOut,
  output logic [SEL_W-1:0]          CurChan,
  output logic                      Changed
);
  localparam int CW = $clog2(DWELL);
  typedef enum logic [1:0] {MANUAL, AUTO, FROZEN} state_t;
  state_t st;
  logic [CW-1:0] cnt, cnt_base, cnt_nx;
  logic [SEL_W-1:0] sel, inc, cur_nx;
  logic [WIDTH-1:0] ch [CHANNELS];
  logic step;
  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    assign ch[k] = DataIn[k*WIDTH +: WIDTH];
  end
  // A scan entered from manual always starts a fresh dwell; a scan resumed from freeze keeps its count.
  always_comb begin
    cnt_base = st == MANUAL ? '0 : cnt;
    step = NextBtn || cnt_base == CW'(DWELL - 1);
    sel = int'(SelectCode) < CHANNELS ? SelectCode : '0;
    inc = CurChan == SEL_W'(CHANNELS - 1) ? '0 : CurChan + SEL_W'(1);
    cur_nx = AutoScan ? (step ? inc : CurChan) : sel;
    cnt_nx = AutoScan && !step ? cnt_base + CW'(1) : '0;
  end
  always_ff @(posedge CLK) begin
    if (Reset) begin
      st <= MANUAL;
      cnt <= '0;
      CurChan <= '0;
      DataOut <= '0;
      Changed <= 1'b0;
    end else if (Freeze) begin
      st <= FROZEN;
      Changed <= 1'b0;
    end else begin
      st <= AutoScan ? AUTO : MANUAL;
      cnt <= cnt_nx;
      CurChan <= cur_nx;
      DataOut <= ch[cur_nx];
      Changed <= cur_nx != CurChan;
    end
  end
endmodule
